qerv_pc_seq: RTL and testbench

//  Parametrised successor to the core's PC control: owns the PC, runs the serial
//  PC update itself (own counter, W bits/cycle, 32/W cycles), then runs the

---
 rtl/qerv_pc_seq.sv | 170 +++++++++++++++++
 tb/tb_qerv_pc_seq.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/qerv_pc_seq.sv
// PC owner for the serial core: bit-serial next-PC computation into a shadow
// register, committed to the fetch address only when the target is legal.
module qerv_pc_seq #(
    parameter int unsigned W               = 1,
    parameter logic [31:0] RESET_PC        = 32'd0,
    parameter bit          WITH_CSR        = 1'b1,
    parameter bit          WITH_COMPRESSED = 1'b0
) (
    input  logic         clk,
    input  logic         i_rst_n,
    input  logic         i_start,
    input  logic         i_jump,
    input  logic         i_trap,
    input  logic         i_iscomp,
    input  logic         i_utype,
    input  logic         i_pc_rel,
    input  logic         i_jal_or_jalr,
    input  logic [W-1:0] i_imm,
    input  logic [W-1:0] i_buf,
    input  logic [W-1:0] i_csr_pc,
    output logic [W-1:0] o_rd,
    output logic [W-1:0] o_bad_pc,
    output logic         o_busy,
    output logic         o_done,
    output logic         o_misalign,
    output logic [31:0]  o_ibus_adr,
    output logic         o_ibus_cyc,
    input  logic         i_ibus_ack
);

    localparam int unsigned N        = 32 / W;
    localparam int unsigned CW       = $clog2(N);
    localparam int unsigned W1       = W + 1;
    localparam int unsigned IMM_CNT  = 12 / W;
    localparam int unsigned BIT1_CNT = 1 / W;
    localparam int unsigned BIT1_POS = 1 % W;

    typedef enum logic [1:0] {S_IDLE, S_UPDATE, S_FETCH} state_t;

    state_t          r_state, w_state_nxt;
    logic [CW-1:0]   r_cnt;
    logic            r_cy4, r_cyo;
    logic [31:0]     r_pc_sr, r_nxt_sr, r_adr;
    logic            r_jump, r_trap, r_iscomp, r_utype, r_pc_rel, r_jal, r_bit1;
    logic            r_busy, r_done, r_misalign, r_cyc;

    logic            w_done_nxt, w_mis_nxt, w_commit;
    logic            w_in_upd, w_last, w_take_trap, w_bad;
    logic [31:0]     w_inc32, w_shamt;
    logic [W-1:0]    w_pc, w_inc, w_pc4, w_offa, w_offb, w_pco, w_csr, w_tgt;
    logic [W:0]      w_sum4, w_sumo;
    logic [31:0]     w_nxt;

    // Per-slice datapath: sequential increment and offset adders
    assign w_in_upd    = (r_state == S_UPDATE);
    assign w_last      = (r_cnt == CW'(N - 1));
    assign w_shamt     = 32'(r_cnt) * W;
    assign w_inc32     = (WITH_COMPRESSED && r_iscomp) ? 32'd2 : 32'd4;
    assign w_inc       = W'(w_inc32 >> w_shamt);
    assign w_pc        = r_pc_sr[W-1:0];
    assign w_sum4      = W1'(w_pc) + W1'(w_inc) + W1'(r_cy4);
    assign w_pc4       = w_sum4[W-1:0];
    assign w_offa      = r_pc_rel ? w_pc : '0;
    assign w_offb      = r_utype ? ((r_cnt >= CW'(IMM_CNT)) ? i_imm : '0) : i_buf;
    assign w_sumo      = W1'(w_offa) + W1'(w_offb) + W1'(r_cyo);
    assign w_pco       = w_sumo[W-1:0] & ~W'(r_cnt == CW'(0));
    assign w_csr       = i_csr_pc & W'(32'hFFFF_FFFC >> w_shamt);
    assign w_take_trap = r_trap & WITH_CSR;
    assign w_tgt       = w_take_trap ? w_csr : (r_jump ? w_pco : w_pc4);
    assign w_nxt       = {w_tgt, r_nxt_sr[31:W]};
    assign w_bad       = r_jump & ~w_take_trap & r_bit1 & ~WITH_COMPRESSED;

    assign o_rd       = w_in_upd ? ((r_utype ? w_pco : '0) | (r_jal ? w_pc4 : '0)) : '0;
    assign o_bad_pc   = w_in_upd ? w_pco : '0;
    assign o_busy     = r_busy;
    assign o_done     = r_done;
    assign o_misalign = r_misalign;
    assign o_ibus_adr = r_adr;
    assign o_ibus_cyc = r_cyc;

    // Next-state and pulse decode
    always_comb begin
        w_state_nxt = r_state;
        w_done_nxt  = 1'b0;
        w_mis_nxt   = 1'b0;
        w_commit    = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (i_start) w_state_nxt = S_UPDATE;
            end
            S_UPDATE: begin
                if (w_last) begin
                    if (w_bad) begin
                        w_state_nxt = S_IDLE;
                        w_done_nxt  = 1'b1;
                        w_mis_nxt   = 1'b1;
                    end else begin
                        w_state_nxt = S_FETCH;
                        w_commit    = 1'b1;
                    end
                end
            end
            S_FETCH: begin
                if (i_ibus_ack) begin
                    w_state_nxt = S_IDLE;
                    w_done_nxt  = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State, registered outputs and serial datapath registers
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_cy4      <= 1'b0;
            r_cyo      <= 1'b0;
            r_pc_sr    <= '0;
            r_nxt_sr   <= '0;
            r_adr      <= RESET_PC;
            r_jump     <= 1'b0;
            r_trap     <= 1'b0;
            r_iscomp   <= 1'b0;
            r_utype    <= 1'b0;
            r_pc_rel   <= 1'b0;
            r_jal      <= 1'b0;
            r_bit1     <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_misalign <= 1'b0;
            r_cyc      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_busy     <= (w_state_nxt != S_IDLE);
            r_cyc      <= (w_state_nxt == S_FETCH);
            r_done     <= w_done_nxt;
            r_misalign <= w_mis_nxt;
            if (w_commit) r_adr <= w_nxt;
            unique case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_cnt    <= '0;
                        r_cy4    <= 1'b0;
                        r_cyo    <= 1'b0;
                        r_bit1   <= 1'b0;
                        r_pc_sr  <= r_adr;
                        r_jump   <= i_jump;
                        r_trap   <= i_trap;
                        r_iscomp <= i_iscomp;
                        r_utype  <= i_utype;
                        r_pc_rel <= i_pc_rel;
                        r_jal    <= i_jal_or_jalr;
                    end
                end
                S_UPDATE: begin
                    r_cnt    <= r_cnt + CW'(1);
                    r_cy4    <= w_last ? 1'b0 : w_sum4[W];
                    r_cyo    <= w_last ? 1'b0 : w_sumo[W];
                    r_pc_sr  <= {w_pc, r_pc_sr[31:W]};
                    r_nxt_sr <= w_nxt;
                    if (r_cnt == CW'(BIT1_CNT)) r_bit1 <= w_pco[BIT1_POS];
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_qerv_pc_seq.sv
// Directed bench: four parameter variants share control stimulus; serial
// operands are sliced per width from 32-bit vectors and results reassembled.
module tb_qerv_pc_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, start, jump, trap, iscomp, utype, pc_rel, jal;
    logic [31:0] imm32, buf32, csr32;
    int          k = 0;
    int          ack_dly = 0;
    int          n_checks = 0;
    int          n_errors = 0;

    // Instance order: a W1 pc0x100 | b W4 pc0xFFFE comp | c W2 pc0x200 | d W1 no-CSR
    logic        imm_a, buf_a, csr_a, rd_a, bad_a, imm_d, buf_d, csr_d, rd_d, bad_d;
    logic [3:0]  imm_b, buf_b, csr_b, rd_b, bad_b;
    logic [1:0]  imm_c, buf_c, csr_c, rd_c, bad_c;
    logic [31:0] adr_a, adr_b, adr_c, adr_d;
    logic [3:0]  busy_v, done_v, mis_v, cyc_v, ack_v;
    int          fcnt [4] = '{0, 0, 0, 0};
    int          wd   [4] = '{1, 4, 2, 1};
    logic [3:0]  rd_v [4];
    logic [3:0]  bad_v [4];

    assign imm_a = 1'(imm32 >> k);       assign buf_a = 1'(buf32 >> k);       assign csr_a = 1'(csr32 >> k);
    assign imm_b = 4'(imm32 >> (4 * k)); assign buf_b = 4'(buf32 >> (4 * k)); assign csr_b = 4'(csr32 >> (4 * k));
    assign imm_c = 2'(imm32 >> (2 * k)); assign buf_c = 2'(buf32 >> (2 * k)); assign csr_c = 2'(csr32 >> (2 * k));
    assign imm_d = imm_a;                assign buf_d = buf_a;                assign csr_d = csr_a;
    assign rd_v[0] = 4'(rd_a);  assign rd_v[1] = rd_b;  assign rd_v[2] = 4'(rd_c);  assign rd_v[3] = 4'(rd_d);
    assign bad_v[0] = 4'(bad_a); assign bad_v[1] = bad_b; assign bad_v[2] = 4'(bad_c); assign bad_v[3] = 4'(bad_d);

    // Fetch responder: ack after ack_dly cycles of request
    for (genvar g = 0; g < 4; g++) begin : g_ack
        assign ack_v[g] = cyc_v[g] && (fcnt[g] == ack_dly);
        always_ff @(posedge clk) fcnt[g] <= cyc_v[g] ? fcnt[g] + 1 : 0;
    end

    qerv_pc_seq #(.W(1), .RESET_PC(32'h100), .WITH_CSR(1'b1), .WITH_COMPRESSED(1'b0)) u_a (
        .clk(clk), .i_rst_n(rst_n), .i_start(start), .i_jump(jump), .i_trap(trap),
        .i_iscomp(iscomp), .i_utype(utype), .i_pc_rel(pc_rel), .i_jal_or_jalr(jal),
        .i_imm(imm_a), .i_buf(buf_a), .i_csr_pc(csr_a), .o_rd(rd_a), .o_bad_pc(bad_a),
        .o_busy(busy_v[0]), .o_done(done_v[0]), .o_misalign(mis_v[0]), .o_ibus_adr(adr_a),
        .o_ibus_cyc(cyc_v[0]), .i_ibus_ack(ack_v[0]));

    qerv_pc_seq #(.W(4), .RESET_PC(32'h0000_FFFE), .WITH_CSR(1'b1), .WITH_COMPRESSED(1'b1)) u_b (
        .clk(clk), .i_rst_n(rst_n), .i_start(start), .i_jump(jump), .i_trap(trap),
        .i_iscomp(iscomp), .i_utype(utype), .i_pc_rel(pc_rel), .i_jal_or_jalr(jal),
        .i_imm(imm_b), .i_buf(buf_b), .i_csr_pc(csr_b), .o_rd(rd_b), .o_bad_pc(bad_b),
        .o_busy(busy_v[1]), .o_done(done_v[1]), .o_misalign(mis_v[1]), .o_ibus_adr(adr_b),
        .o_ibus_cyc(cyc_v[1]), .i_ibus_ack(ack_v[1]));

    qerv_pc_seq #(.W(2), .RESET_PC(32'h200), .WITH_CSR(1'b1), .WITH_COMPRESSED(1'b0)) u_c (
        .clk(clk), .i_rst_n(rst_n), .i_start(start), .i_jump(jump), .i_trap(trap),
        .i_iscomp(iscomp), .i_utype(utype), .i_pc_rel(pc_rel), .i_jal_or_jalr(jal),
        .i_imm(imm_c), .i_buf(buf_c), .i_csr_pc(csr_c), .o_rd(rd_c), .o_bad_pc(bad_c),
        .o_busy(busy_v[2]), .o_done(done_v[2]), .o_misalign(mis_v[2]), .o_ibus_adr(adr_c),
        .o_ibus_cyc(cyc_v[2]), .i_ibus_ack(ack_v[2]));

    qerv_pc_seq #(.W(1), .RESET_PC(32'h100), .WITH_CSR(1'b0), .WITH_COMPRESSED(1'b0)) u_d (
        .clk(clk), .i_rst_n(rst_n), .i_start(start), .i_jump(jump), .i_trap(trap),
        .i_iscomp(iscomp), .i_utype(utype), .i_pc_rel(pc_rel), .i_jal_or_jalr(jal),
        .i_imm(imm_d), .i_buf(buf_d), .i_csr_pc(csr_d), .o_rd(rd_d), .o_bad_pc(bad_d),
        .o_busy(busy_v[3]), .o_done(done_v[3]), .o_misalign(mis_v[3]), .o_ibus_adr(adr_d),
        .o_ibus_cyc(cyc_v[3]), .i_ibus_ack(ack_v[3]));

    logic [31:0] rdv [4];
    logic [31:0] badv [4];
    int          ncyc [4], ndone [4], nmis [4], ncoin [4], first_cyc [4];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic reset_pulse();
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
    endtask

    // One operation on all instances over a fixed 48-cycle window
    task automatic run_op(input int dly, input bit poke);
        ack_dly = dly;
        for (int i = 0; i < 4; i++) begin
            rdv[i] = '0; badv[i] = '0; ncyc[i] = 0; ndone[i] = 0;
            nmis[i] = 0; ncoin[i] = 0; first_cyc[i] = 0;
        end
        @(negedge clk); start = 1'b1; k = 0;
        for (int c = 1; c <= 48; c++) begin
            @(negedge clk);
            start = poke && (c == 10);
            k = c - 1;
            #1;
            for (int i = 0; i < 4; i++) begin
                if (k < 32 / wd[i] && busy_v[i]) begin
                    rdv[i]  |= 32'(rd_v[i])  << (k * wd[i]);
                    badv[i] |= 32'(bad_v[i]) << (k * wd[i]);
                end
                if (cyc_v[i]) begin
                    ncyc[i]++;
                    if (first_cyc[i] == 0) first_cyc[i] = c;
                end
                if (done_v[i]) ndone[i]++;
                if (mis_v[i]) nmis[i]++;
                if (mis_v[i] && done_v[i]) ncoin[i]++;
            end
        end
        start = 1'b0;
        check("idle_after_op", 32'(busy_v), 32'h0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; jump = 1'b0; trap = 1'b0; iscomp = 1'b0;
        utype = 1'b0; pc_rel = 1'b0; jal = 1'b0; imm32 = '0; buf32 = '0; csr32 = '0;
        repeat (3) @(negedge clk);
        check("rst_adr_a", adr_a, 32'h100);
        check("rst_adr_b", adr_b, 32'h0000_FFFE);
        check("rst_flags", {busy_v, cyc_v, done_v, mis_v}, 32'h0);
        check("rst_serial", {bad_v[0], bad_v[1], rd_v[0], rd_v[1], rd_v[2]}, 32'h0);
        rst_n = 1'b1;

        // Sequential +4 (+2 compressed on b), late ack, stray start mid-op
        iscomp = 1'b1; jal = 1'b1;
        run_op(3, 1'b1);
        check("inc_adr_a", adr_a, 32'h104);
        check("inc_adr_b", adr_b, 32'h0001_0000);
        check("inc_adr_c", adr_c, 32'h204);
        check("inc_rd_a", rdv[0], 32'h104);
        check("inc_rd_b", rdv[1], 32'h0001_0000);
        check("inc_cyc_len_a", 32'(ncyc[0]), 32'd4);
        check("inc_latency_a", 32'(first_cyc[0]), 32'd33);
        check("inc_latency_b", 32'(first_cyc[1]), 32'd9);
        check("inc_done_a", 32'(ndone[0]), 32'd1);
        check("inc_mis_a", 32'(nmis[0]), 32'd0);

        // Branch pc+0xA: misaligned without compressed support
        reset_pulse();
        iscomp = 1'b0; jal = 1'b0; jump = 1'b1; pc_rel = 1'b1; buf32 = 32'h0000_000A;
        run_op(0, 1'b0);
        check("mis_adr_c", adr_c, 32'h200);
        check("mis_cnt_c", 32'(nmis[2]), 32'd1);
        check("mis_with_done_c", 32'(ncoin[2]), 32'd1);
        check("mis_done_c", 32'(ndone[2]), 32'd1);
        check("mis_nocyc_c", 32'(ncyc[2]), 32'd0);
        check("mis_bad_c", badv[2], 32'h20A);
        check("mis_adr_a", adr_a, 32'h100);
        check("jmp_adr_b", adr_b, 32'h0001_0008);
        check("jmp_mis_b", 32'(nmis[1]), 32'd0);
        check("jmp_cyc_b", 32'(ncyc[1]), 32'd1);

        // Absolute jump to 0x1000, then AUIPC with low imm bits masked
        pc_rel = 1'b0; buf32 = 32'h0000_1000;
        run_op(0, 1'b0);
        check("abs_adr_b", adr_b, 32'h1000);
        jump = 1'b0; utype = 1'b1; pc_rel = 1'b1; imm32 = 32'h1234_5ABC; buf32 = '0;
        run_op(0, 1'b0);
        check("auipc_rd_b", rdv[1], 32'h1234_6000);
        check("auipc_rd_a", rdv[0], 32'h1234_6000);
        check("auipc_rd_c", rdv[2], 32'h1234_6000);
        check("auipc_adr_b", adr_b, 32'h1004);
        check("auipc_adr_a", adr_a, 32'h1004);

        // Trap beats a misaligned jump; without CSR the jump is taken
        reset_pulse();
        utype = 1'b0; pc_rel = 1'b0; imm32 = '0;
        trap = 1'b1; jump = 1'b1; csr32 = 32'h8000_0003; buf32 = 32'h0000_0042;
        run_op(0, 1'b0);
        check("trap_adr_a", adr_a, 32'h8000_0000);
        check("trap_mis_a", 32'(nmis[0]), 32'd0);
        check("trap_adr_b", adr_b, 32'h8000_0000);
        check("nocsr_mis_d", 32'(nmis[3]), 32'd1);
        check("nocsr_adr_d", adr_d, 32'h100);
        check("nocsr_bad_d", badv[3], 32'h42);

        // Reset during UPDATE at cnt=5, then a clean restart
        reset_pulse();
        trap = 1'b0; jump = 1'b0; csr32 = '0; buf32 = '0; jal = 1'b1;
        @(negedge clk); start = 1'b1; k = 0;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk); start = 1'b0; k = c - 1;
        end
        #1;
        check("abort_busy_before", 32'(busy_v[0]), 32'h1);
        rst_n = 1'b0;
        #1;
        check("abort_adr_a", adr_a, 32'h100);
        check("abort_flags", {busy_v, cyc_v, done_v, mis_v}, 32'h0);
        check("abort_rd_a", 32'(rd_v[0]), 32'h0);
        @(negedge clk); rst_n = 1'b1;
        jal = 1'b0;
        run_op(0, 1'b0);
        check("restart_adr_a", adr_a, 32'h104);
        check("restart_done_a", 32'(ndone[0]), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
